// File: rtl/binary_game_core.sv
// Game controller for the binary-counting DIP-switch game: shows a random target,
// waits for a held matching guess, tracks score, lives and a per-round time limit.
module binary_game_core #(
  parameter  int WIDTH    = 8,
  parameter  int LIVES    = 3,
  parameter  int BASETIME = 30,
  parameter  int MINTIME  = 10,
  parameter  int HOLD     = 4,
  parameter  int WARN     = 5,
  parameter  int TIME_W   = 8,
  localparam int LIVES_W  = ($clog2(LIVES + 1) < 2) ? 2 : $clog2(LIVES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [WIDTH-1:0]   guess,
  input  logic               start,
  input  logic               practice,
  input  logic               tick,
  input  logic [WIDTH-1:0]   rnd,
  output logic [WIDTH-1:0]   disp_value,
  output logic               disp_trigger,
  input  logic               disp_done,
  output logic [WIDTH-1:0]   score,
  output logic [LIVES_W-1:0] lives_left,
  output logic [TIME_W-1:0]  time_left,
  output logic               point,
  output logic               guessing,
  output logic               game_over
);

  localparam int CW     = (WIDTH > TIME_W) ? WIDTH : TIME_W;
  localparam int HOLD_W = ($clog2(HOLD + 1) < 1) ? 1 : $clog2(HOLD + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHOW, GUESS, MISS, REPORT, OVER} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   target, target_n;
  logic               practice_mode, practice_mode_n;
  logic [HOLD_W-1:0]  hold, hold_n;
  logic [WIDTH-1:0]   disp_value_n, score_n;
  logic               disp_trigger_n, point_n, guessing_n, game_over_n;
  logic [LIVES_W-1:0] lives_n, lives_dec;
  logic [TIME_W-1:0]  time_n, limit;
  logic [CW-1:0]      score_ext, limit_wide;
  logic               match_done, expire;

  // Round time limit shrinks by one second per point until it hits the floor.
  always_comb begin
    score_ext = CW'(score);
    if (score_ext < CW'(BASETIME - MINTIME))
      limit_wide = CW'(BASETIME) - score_ext;
    else
      limit_wide = CW'(MINTIME);
    limit = limit_wide[TIME_W-1:0];
  end

  always_comb begin
    state_n         = state;
    target_n        = target;
    practice_mode_n = practice_mode;
    hold_n          = hold;
    disp_value_n    = disp_value;
    disp_trigger_n  = 1'b0;
    score_n         = score;
    lives_n         = lives_left;
    time_n          = time_left;
    point_n         = point;
    match_done      = 1'b0;
    expire          = 1'b0;
    lives_dec       = lives_left - LIVES_W'(1);

    case (state)
      IDLE, OVER: begin
        if (start) begin
          state_n         = LOAD;
          practice_mode_n = practice;
          score_n         = '0;
          lives_n         = LIVES_W'(LIVES);
        end
      end
      LOAD: begin
        if (rnd != '0 && rnd != guess) begin
          target_n       = rnd;
          disp_value_n   = rnd;
          disp_trigger_n = 1'b1;
          state_n        = SHOW;
        end
      end
      // disp_trigger is high only on the first cycle, so it doubles as the ignore-done flag.
      SHOW: begin
        if (!disp_trigger && disp_done) begin
          state_n = GUESS;
          time_n  = limit;
          hold_n  = '0;
          point_n = 1'b0;
        end
      end
      GUESS: begin
        if (guess == target) begin
          hold_n     = hold + HOLD_W'(1);
          match_done = (hold == HOLD_W'(HOLD - 1));
        end else begin
          hold_n = '0;
        end
        if (!practice_mode && tick) begin
          if (time_left <= TIME_W'(WARN)) point_n = ~point;
          if (time_left != '0) time_n = time_left - TIME_W'(1);
          expire = (time_left == TIME_W'(1));
        end
        // A completed match takes priority over an expiring tick.
        if (match_done) begin
          score_n = (score == '1) ? score : score + WIDTH'(1);
          hold_n  = '0;
          state_n = LOAD;
        end else if (expire) begin
          hold_n  = '0;
          state_n = MISS;
        end
      end
      MISS: begin
        lives_n = lives_dec;
        if (lives_dec == '0) begin
          disp_value_n   = score;
          disp_trigger_n = 1'b1;
          state_n        = REPORT;
        end else begin
          state_n = LOAD;
        end
      end
      REPORT: begin
        if (!disp_trigger && disp_done) state_n = OVER;
      end
      default: state_n = IDLE;
    endcase

    if (state_n != GUESS) point_n = 1'b0;
    guessing_n  = (state_n == GUESS);
    game_over_n = (state_n == OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      target        <= '0;
      practice_mode <= 1'b0;
      hold          <= '0;
      disp_value    <= '0;
      disp_trigger  <= 1'b0;
      score         <= '0;
      lives_left    <= LIVES_W'(LIVES);
      time_left     <= '0;
      point         <= 1'b0;
      guessing      <= 1'b0;
      game_over     <= 1'b0;
    end else if (ena) begin
      state         <= state_n;
      target        <= target_n;
      practice_mode <= practice_mode_n;
      hold          <= hold_n;
      disp_value    <= disp_value_n;
      disp_trigger  <= disp_trigger_n;
      score         <= score_n;
      lives_left    <= lives_n;
      time_left     <= time_n;
      point         <= point_n;
      guessing      <= guessing_n;
      game_over     <= game_over_n;
    end
  end

endmodule

// File: tb/tb_binary_game_core.sv
// Directed bench for binary_game_core with default parameters; expected values
// are hand-computed from the game rules.
module tb_binary_game_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] guess = 8'h00;
  logic       start = 1'b0;
  logic       practice = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] rnd = 8'h00;
  logic [7:0] disp_value;
  logic       disp_trigger;
  logic       disp_done = 1'b0;
  logic [7:0] score;
  logic [1:0] lives_left;
  logic [7:0] time_left;
  logic       point;
  logic       guessing;
  logic       game_over;

  int vectors = 0;
  int miscompares = 0;

  binary_game_core dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .guess(guess), .start(start),
    .practice(practice), .tick(tick), .rnd(rnd), .disp_value(disp_value),
    .disp_trigger(disp_trigger), .disp_done(disp_done), .score(score),
    .lives_left(lives_left), .time_left(time_left), .point(point),
    .guessing(guessing), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseTick();
    tick = 1'b1;
    cycle(1);
    tick = 1'b0;
  endtask

  task automatic pulseDone();
    disp_done = 1'b1;
    cycle(1);
    disp_done = 1'b0;
  endtask

  // From LOAD: show v, acknowledge the display, then hold the matching guess.
  task automatic applyStimulus(input logic [7:0] v);
    rnd   = v;
    guess = 8'h00;
    cycle(2);
    pulseDone();
    guess = v;
    cycle(4);
  endtask

  // From GUESS at 29 s in timed mode: let the clock run out and leave MISS.
  task automatic missRound();
    repeat (29) pulseTick();
    cycle(1);
  endtask

  initial begin
    cycle(2);
    checkOutput("rst_score", 32'(score), 32'd0);
    checkOutput("rst_lives", 32'(lives_left), 32'd3);
    checkOutput("rst_time", 32'(time_left), 32'd0);
    checkOutput("rst_flags", {28'd0, point, guessing, game_over, disp_trigger}, 32'd0);
    checkOutput("rst_disp", 32'(disp_value), 32'd0);

    rst_n = 1'b1;
    guess = 8'h01;
    start = 1'b1;
    cycle(1);
    start = 1'b0;
    cycle(2);
    checkOutput("load_zero_trig", 32'(disp_trigger), 32'd0);
    rnd = 8'h5A;
    cycle(1);
    checkOutput("show_trig", 32'(disp_trigger), 32'd1);
    checkOutput("show_value", 32'(disp_value), 32'h5A);
    pulseDone();
    checkOutput("show_trig_once", 32'(disp_trigger), 32'd0);
    checkOutput("done_ignored", 32'(guessing), 32'd0);
    pulseDone();
    checkOutput("guess_entry", 32'(guessing), 32'd1);
    checkOutput("time_30", 32'(time_left), 32'd30);
    checkOutput("point_entry", 32'(point), 32'd0);

    guess = 8'h5A;
    cycle(3);
    checkOutput("hold3_score", 32'(score), 32'd0);
    guess = 8'h00;
    cycle(1);
    guess = 8'h5A;
    cycle(3);
    checkOutput("rehold3_score", 32'(score), 32'd0);
    cycle(1);
    checkOutput("hold4_score", 32'(score), 32'd1);
    checkOutput("hold4_leave", 32'(guessing), 32'd0);
    cycle(1);
    checkOutput("load_eq_guess", 32'(disp_trigger), 32'd0);
    rnd   = 8'h33;
    guess = 8'h00;
    cycle(1);
    checkOutput("show2_value", 32'(disp_value), 32'h33);
    cycle(1);
    pulseDone();
    checkOutput("time_29", 32'(time_left), 32'd29);

    repeat (23) pulseTick();
    checkOutput("t6_time", 32'(time_left), 32'd6);
    checkOutput("t6_point", 32'(point), 32'd0);
    pulseTick();
    checkOutput("t5_point", 32'(point), 32'd0);
    pulseTick();
    checkOutput("t4_point", 32'(point), 32'd1);
    pulseTick();
    checkOutput("t3_point", 32'(point), 32'd0);
    pulseTick();
    checkOutput("t2_point", 32'(point), 32'd1);
    pulseTick();
    checkOutput("t1_time", 32'(time_left), 32'd1);
    checkOutput("t1_point", 32'(point), 32'd0);
    pulseTick();
    checkOutput("miss_time", 32'(time_left), 32'd0);
    checkOutput("miss_guessing", 32'(guessing), 32'd0);
    cycle(1);
    checkOutput("miss1_lives", 32'(lives_left), 32'd2);
    cycle(1);
    checkOutput("round2_trig", 32'(disp_trigger), 32'd1);
    cycle(1);
    pulseDone();
    checkOutput("round2_time", 32'(time_left), 32'd29);
    missRound();
    checkOutput("miss2_lives", 32'(lives_left), 32'd1);
    cycle(2);
    pulseDone();
    missRound();
    checkOutput("miss3_lives", 32'(lives_left), 32'd0);
    checkOutput("report_value", 32'(disp_value), 32'd1);
    checkOutput("report_trig", 32'(disp_trigger), 32'd1);
    checkOutput("report_not_over", 32'(game_over), 32'd0);
    cycle(1);
    pulseDone();
    checkOutput("over", 32'(game_over), 32'd1);

    start = 1'b1;
    cycle(1);
    start = 1'b0;
    checkOutput("restart_score", 32'(score), 32'd0);
    checkOutput("restart_lives", 32'(lives_left), 32'd3);
    checkOutput("restart_over", 32'(game_over), 32'd0);
    repeat (25) applyStimulus(8'h2C);
    checkOutput("score_25", 32'(score), 32'd25);
    rnd   = 8'h2C;
    guess = 8'h00;
    cycle(2);
    pulseDone();
    checkOutput("time_floor", 32'(time_left), 32'd10);
    repeat (6) pulseTick();
    checkOutput("floor_t4_point", 32'(point), 32'd1);
    repeat (3) pulseTick();
    checkOutput("floor_t1_time", 32'(time_left), 32'd1);
    guess = 8'h2C;
    cycle(3);
    tick = 1'b1;
    cycle(1);
    tick = 1'b0;
    checkOutput("tie_score", 32'(score), 32'd26);
    checkOutput("tie_lives", 32'(lives_left), 32'd3);
    cycle(1);
    checkOutput("tie_lives_after", 32'(lives_left), 32'd3);

    rnd   = 8'h40;
    guess = 8'h00;
    cycle(2);
    pulseDone();
    checkOutput("pre_reset_guess", 32'(guessing), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_score", 32'(score), 32'd0);
    checkOutput("async_lives", 32'(lives_left), 32'd3);
    checkOutput("async_time", 32'(time_left), 32'd0);
    checkOutput("async_flags", {30'd0, point, guessing}, 32'd0);
    cycle(1);
    rst_n = 1'b1;

    practice = 1'b1;
    start    = 1'b1;
    cycle(1);
    start    = 1'b0;
    practice = 1'b0;
    cycle(2);
    pulseDone();
    checkOutput("prac_time", 32'(time_left), 32'd30);
    repeat (100) pulseTick();
    checkOutput("prac_time_held", 32'(time_left), 32'd30);
    checkOutput("prac_lives", 32'(lives_left), 32'd3);
    checkOutput("prac_point", 32'(point), 32'd0);
    checkOutput("prac_guessing", 32'(guessing), 32'd1);

    ena   = 1'b0;
    guess = 8'h40;
    cycle(4);
    pulseTick();
    disp_done = 1'b1;
    cycle(5);
    disp_done = 1'b0;
    checkOutput("frozen_score", 32'(score), 32'd0);
    checkOutput("frozen_guessing", 32'(guessing), 32'd1);
    ena = 1'b1;
    cycle(3);
    checkOutput("thaw_hold3", 32'(score), 32'd0);
    cycle(1);
    checkOutput("thaw_hold4", 32'(score), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
